// File: rtl/timer_peri_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : timer_peri_pkg                                            |
// | Purpose  : Shared constants and types for the timer peripheral:      |
// |            peripheral bus addresses, reset prescaler value and the   |
// |            read-select encoding used by the address decoder.         |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package timer_peri_pkg;

  // Peripheral bus map shared with the CPU pipeline.
  localparam logic [31:0] PERI_ADDR_TIM = 32'hFFFF_F020;
  localparam logic [31:0] PERI_ADDR_FRE = 32'hFFFF_F024;

  // A zero prescaler keeps the timer stopped until software programs it.
  localparam logic [31:0] FRE_RESET_DEFAULT = 32'd0;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_TIM  = 2'd1,
    SEL_FRE  = 2'd2
  } rd_sel_e;

  // Full 32-bit compare; any other address selects nothing.
  function automatic rd_sel_e decode_addr(input logic [31:0] addr,
                                          input logic [31:0] addr_tim,
                                          input logic [31:0] addr_fre);
    rd_sel_e sel;
    sel = SEL_NONE;
    if (addr == addr_tim)      sel = SEL_TIM;
    else if (addr == addr_fre) sel = SEL_FRE;
    return sel;
  endfunction

endpackage : timer_peri_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : timer_prescaler                                           |
// | Purpose  : Divides clk by fre, producing a one-cycle tick every fre  |
// |            cycles. fre == 0 stops the divider entirely.              |
// | Ports    : clk  - system clock                                       |
// |            rst  - synchronous active-high reset                      |
// |            fre  - reload value (cycles per tick)                     |
// |            clr  - restart the divider from 0 (register write)        |
// |            tick - high in the last cycle of each fre-cycle period    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fre,
  input  logic        clr,
  output logic        tick
);

  logic [31:0] div;
  logic        running;

  assign running = (fre != 32'd0);

  // tick depends only on the current fre/div, so a tick coincident with a
  // prescaler write is still judged against the old reload value.
  assign tick = running && (div == (fre - 32'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= 32'd0;
    end else if (clr || !running || tick) begin
      div <= 32'd0;
    end else begin
      div <= div + 32'd1;
    end
  end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/timer_peri.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : timer_peri                                                |
// | Purpose  : Memory-mapped free-running timer. Holds a 32-bit count    |
// |            (TIM) advanced once every FRE cycles, and the prescaler   |
// |            reload register (FRE). Reads are combinational.           |
// | Ports    : clk   - system clock                                      |
// |            rst   - synchronous active-high reset                     |
// |            addr  - CPU byte address                                  |
// |            we    - CPU write strobe                                  |
// |            wdata - CPU write data                                    |
// |            rdata - read data for addr (0 when unmapped)              |
// |            ovf   - one-cycle pulse after the count wraps to 0        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module timer_peri
  import timer_peri_pkg::*;
#(
  parameter logic [31:0] ADDR_TIM  = PERI_ADDR_TIM,
  parameter logic [31:0] ADDR_FRE  = PERI_ADDR_FRE,
  parameter logic [31:0] FRE_RESET = FRE_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ovf
);

  rd_sel_e     sel;
  logic        wr_tim;
  logic        wr_fre;
  logic        tick;
  logic [31:0] cnt;
  logic [31:0] fre;

  assign sel    = decode_addr(addr, ADDR_TIM, ADDR_FRE);
  assign wr_tim = we && (sel == SEL_TIM);
  assign wr_fre = we && (sel == SEL_FRE);

  timer_prescaler u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .fre  (fre),
    .clr  (wr_tim || wr_fre),
    .tick (tick)
  );

  // A count write overrides a coincident tick, so neither the increment
  // nor the overflow pulse happens in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 32'd0;
      ovf <= 1'b0;
    end else begin
      ovf <= tick && !wr_tim && (cnt == 32'hFFFF_FFFF);
      if (wr_tim) begin
        cnt <= wdata;
      end else if (tick) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fre <= FRE_RESET;
    end else if (wr_fre) begin
      fre <= wdata;
    end
  end

  // Zero-latency read: a load sees the current (pre-write) register value.
  always_comb begin
    rdata = 32'h0;
    case (sel)
      SEL_TIM: rdata = cnt;
      SEL_FRE: rdata = fre;
      default: rdata = 32'h0;
    endcase
  end

endmodule : timer_peri
`default_nettype wire

// File: tb/tb_timer_peri.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_timer_peri                                             |
// | Purpose  : Self-checking bench for timer_peri: directed vector table,|
// |            reset-during-write sequence and randomized traffic        |
// |            compared against a cycle-level behavioural model.         |
// | Ports    : none                                                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_timer_peri;

  localparam logic [31:0] A_TIM   = 32'hFFFF_F020;
  localparam logic [31:0] A_FRE   = 32'hFFFF_F024;
  localparam logic [31:0] A_OTHER = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  timer_peri dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .ovf   (ovf)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [31:0] a, input logic w,
                              input logic [31:0] d, input logic [31:0] er,
                              input logic eo);
    vec_t v;
    v.addr = a; v.we = w; v.wdata = d; v.exp_rdata = er; v.exp_ovf = eo;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  // Behavioural model: the count advances on every fre-th cycle since the
  // last restart (reset or register write), measured with plain modulo.
  logic [31:0] m_cnt, m_fre;
  int unsigned m_age;
  logic        m_ovf;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == A_TIM) return m_cnt;
    if (a == A_FRE) return m_fre;
    return 32'h0;
  endfunction

  function automatic void m_step(input logic r, input logic [31:0] a,
                                 input logic w, input logic [31:0] d);
    logic t, wt, wf;
    if (r) begin
      m_cnt = 0; m_fre = 0; m_age = 0; m_ovf = 0;
      return;
    end
    t  = (m_fre != 0) && ((m_age % m_fre) == m_fre - 1);
    wt = w && (a == A_TIM);
    wf = w && (a == A_FRE);
    m_ovf = t && !wt && (m_cnt == 32'hFFFF_FFFF);
    if (wt)     m_cnt = d;
    else if (t) m_cnt = m_cnt + 1;
    if (wf) m_fre = d;
    m_age = (wt || wf) ? 0 : m_age + 1;
  endfunction

  task automatic drive(input logic r, input logic [31:0] a, input logic w,
                       input logic [31:0] d);
    @(negedge clk);
    rst = r; addr = a; we = w; wdata = d;
    #1;
  endtask

  // One cycle checked against the model, then the model advances.
  task automatic mstep(input string tag, input logic r, input logic [31:0] a,
                       input logic w, input logic [31:0] d);
    drive(r, a, w, d);
    check({tag, "_rdata"}, rdata, m_read(a));
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
    m_step(r, a, w, d);
  endtask

  initial begin
    // Directed table, starting from reset.
    for (int i = 0; i < 20; i++) add((i % 2) ? A_FRE : A_TIM, 0, 0, 0, 0);
    add(A_FRE, 1, 4, 0, 0);
    for (int k = 1; k <= 12; k++) add(A_TIM, 0, 0, 32'((k - 1) / 4), 0);
    add(A_TIM, 0, 0, 3, 0);
    add(A_FRE, 0, 0, 4, 0);
    add(A_FRE, 1, 1, 4, 0);
    add(A_TIM, 1, 32'hFFFF_FFFE, 3, 0);
    add(A_TIM, 0, 0, 32'hFFFF_FFFE, 0);
    add(A_TIM, 0, 0, 32'hFFFF_FFFF, 0);
    add(A_TIM, 0, 0, 0, 1);
    add(A_TIM, 0, 0, 1, 0);
    add(A_FRE, 1, 2, 1, 0);
    add(A_TIM, 0, 0, 3, 0);
    add(A_TIM, 1, 100, 3, 0);
    add(A_TIM, 0, 0, 100, 0);
    add(A_TIM, 0, 0, 100, 0);
    add(A_TIM, 0, 0, 101, 0);
    add(A_OTHER, 1, 5, 0, 0);
    add(A_TIM, 0, 0, 102, 0);
    add(A_FRE, 0, 0, 2, 0);

    drive(1, 0, 0, 0);
    m_step(1, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(0, vecs[i].addr, vecs[i].we, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
    end

    // Reset mid-count while a TIM write is presented: write discarded.
    drive(1, 0, 0, 0);
    m_step(1, 0, 0, 0);
    mstep("rs_fre", 0, A_FRE, 1, 3);
    for (int i = 0; i < 8; i++) mstep("rs_run", 0, A_TIM, 0, 0);
    check("rs_running", rdata, 32'd2);
    mstep("rs_rst", 1, A_TIM, 1, 55);
    mstep("rs_after", 0, A_TIM, 0, 0);
    check("rs_tim_zero", rdata, 32'd0);
    mstep("rs_fre_rd", 0, A_FRE, 0, 0);
    check("rs_fre_zero", rdata, 32'd0);
    for (int i = 0; i < 6; i++) mstep("rs_stop", 0, A_TIM, 0, 0);
    check("rs_stopped", rdata, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [31:0] a, d;
      logic w, rr;
      r = $urandom % 16;
      w = 0; d = $urandom; rr = 0;
      case (r)
        0: begin a = A_FRE; w = 1; d = $urandom_range(0, 5); end
        1: begin
          a = A_TIM; w = 1;
          d = ($urandom % 4 == 0) ? $urandom : 32'hFFFF_FFFC + ($urandom % 4);
        end
        2: begin
          a = $urandom;
          if (a == A_TIM || a == A_FRE) a = a ^ 32'h1;
          w = 1;
        end
        3: a = A_OTHER;
        4, 5, 6, 7, 8: a = A_FRE;
        default: a = A_TIM;
      endcase
      if (r == 15 && ($urandom % 8) == 0) rr = 1;
      mstep("rand", rr, a, w, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_timer_peri
`default_nettype wire

// File: doc/timer_peri.md
Name: timer_peri

Overview:
- Memory-mapped free-running timer peripheral; the responder side of the CPU peripheral bus at the timer and frequency-divider addresses.
- Holds a 32-bit count register (TIM) and a 32-bit prescaler reload register (FRE).
- The count advances once every FRE clock cycles.
- CPU writes load either register; CPU reads return either register combinationally, within the same cycle.

Parameters:
ADDR_TIM, 32'hFFFF_F020, byte address of the count register (shared define PERI_ADDR_TIM)
ADDR_FRE, 32'hFFFF_F024, byte address of the prescaler register (shared define PERI_ADDR_FRE)
FRE_RESET, 32'd0, prescaler value after reset (0 = timer stopped)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
addr  input  32  CPU byte address, full 32-bit compare
we  input  1  CPU write strobe; acts only when addr matches ADDR_TIM or ADDR_FRE
wdata  input  32  CPU write data
rdata  output  32  read data, combinational from addr and register state
ovf  output  1  one-cycle pulse when the count wraps from 32'hFFFF_FFFF to 0

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst). All state updates on the posedge of clk.
- Reset (rst=1 at posedge):
  - cnt=0, fre=FRE_RESET, div=0, ovf=0.
  - rst has priority over every write and every tick.
- Address decode:
  - hit_tim = (addr==ADDR_TIM); hit_fre = (addr==ADDR_FRE).
  - we with neither hit: ignored, no state change.
  - The decode is done internally; the block does not rely on upstream write qualification.
- Prescaler (div, 32-bit):
  - fre==0: div holds 0, no ticks, cnt frozen.
  - fre!=0: div counts 0..fre-1. tick=1 in the cycle where div==fre-1; div then returns to 0.
  - fre==1: tick every cycle.
- Count: on tick, cnt <= cnt+1 modulo 2^32.
- Overflow: ovf is registered; it is 1 in the cycle after a tick that takes cnt from 32'hFFFF_FFFF to 0, else 0.
- Write to TIM (we & hit_tim): cnt <= wdata; div <= 0.
  - The write wins over a coincident tick: no increment, no ovf.
- Write to FRE (we & hit_fre): fre <= wdata; div <= 0; cnt unchanged.
  - A tick coincident with the write still increments cnt, using the old fre.
- Read path:
  - rdata = cnt if hit_tim; fre if hit_fre; else 32'h0.
  - Purely combinational, zero-cycle latency, so a load in MEM sees the value in the same cycle.
  - A write at edge N is visible to a read in cycle N+1.
  - Read during the write cycle returns the pre-write value.
- Out-of-range: no error response; unmapped reads return 0.

Decomposition:
- Shared include defines_pipeline.vh: PERI_ADDR_TIM, PERI_ADDR_FRE (default the parameters to these).
- Sub-module timer_prescaler:
  - inputs: clk, rst, fre, clr (FRE or TIM write).
  - output: tick.
  - owns div and the fre==0 stop rule.
- The top level owns cnt, fre, decode, read mux and ovf.

Test Plan:
- Reset with FRE_RESET=0, 20 idle cycles -> rdata@ADDR_TIM=0, rdata@ADDR_FRE=0, ovf never 1.
- Write FRE=4, then 12 idle cycles -> TIM reads 3; ticks exactly on cycles 4, 8, 12 after the write.
- Write TIM=32'hFFFF_FFFE with FRE=1 -> reads FFFF_FFFF, then 0; ovf is a single-cycle pulse one cycle after the wrap; the next read is 1.
- FRE=2; write TIM=100 in the cycle a tick is due -> TIM=100 next cycle (tick lost, div restarted); reads 101 two cycles later.
- we=1 at addr=32'hFFFF_F000 with wdata=5 -> TIM and FRE unchanged; rdata=0 at that address.
- Running with FRE=3, assert rst for one cycle mid-count while we=1 targets TIM -> cnt=0, fre=0, counting stops, write discarded.
